// File: rtl/fetch_unit.sv
// Per-thread fetch: walks the PC, reads four bytes per word over a byte-wide memory port and buffers {word, pc}.
// First word is visible 5 cycles after enable with an always-ready memory; a full buffer holds off new words, and mem_ready low stalls the current byte.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_inst_valid,
  output logic [31:0]       o_inst_data,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  output logic              o_busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_buf_dat [DEPTH];
  logic [ADDR_W-1:0] r_buf_pc  [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_start;
  logic [CW-1:0]     w_count_upd;

  always_comb begin
    w_hs        = (r_state == S_FETCH) && i_mem_ready;
    w_push      = w_hs && (r_bcnt == 2'd3);
    w_pop       = (r_count != '0) && i_inst_ready;
    w_count_upd = r_count + CW'(w_push) - CW'(w_pop);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_enable && (r_count < DEPTH_C)) w_state_nxt = S_FETCH;
      S_FETCH: if (w_push && !(i_enable && (w_count_upd < DEPTH_C))) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_redirect_valid) w_state_nxt = S_IDLE;
    w_start = (r_state == S_IDLE) && (w_state_nxt == S_FETCH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_bcnt       <= 2'd0;
      r_asm        <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf_dat[i] <= '0;
        r_buf_pc[i]  <= '0;
      end
    end else if (i_redirect_valid) begin
      // Flush wins over everything, including a byte or pop landing this cycle.
      r_state  <= S_IDLE;
      r_pc     <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
      r_bcnt   <= 2'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_upd;
      if (w_start) begin
        r_fetch_addr <= r_pc;
        r_bcnt       <= 2'd0;
      end
      if (w_hs) begin
        // After the last byte fetch_addr lands on pc+4, ready for the back-to-back word.
        r_fetch_addr <= r_fetch_addr + 1'b1;
        r_bcnt       <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_asm[7:0]   <= i_mem_rdata;
          2'd1:    r_asm[15:8]  <= i_mem_rdata;
          2'd2:    r_asm[23:16] <= i_mem_rdata;
          default: ;
        endcase
      end
      if (w_push) begin
        r_buf_dat[r_wr_ptr] <= {i_mem_rdata, r_asm};
        r_buf_pc[r_wr_ptr]  <= r_pc;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
        r_pc                <= r_pc + ADDR_W'(4);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_mem_req    = (r_state == S_FETCH);
  assign o_busy       = (r_state == S_FETCH);
  assign o_mem_addr   = r_fetch_addr;
  assign o_inst_valid = (r_count != '0);
  assign o_inst_data  = r_buf_dat[r_rd_ptr];
  assign o_inst_pc    = r_buf_pc[r_rd_ptr];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Per-thread instruction fetch stage that sits directly upstream of the thread core's decode and register-file logic. It walks a program counter, issues byte-wide read requests to the shared L3 memory port, and assembles four little-endian bytes into a 32-bit instruction word. Each word and its PC go into a small instruction buffer, which is drained by the core through a valid/ready handshake. It also handles control-flow redirects (branch/jump) by flushing buffered and partially assembled words.

## Interface
- ADDR_W, 32, width of PC and memory address
- RESET_PC, 0, PC loaded on reset (bits [1:0] must be 0)
- DEPTH, 2, instruction buffer entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- enable  in  1  thread fetch enable
- redirect_valid  in  1  load new PC, flush pipeline
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address of request
- mem_ready  in  1  request accepted; mem_rdata valid this cycle
- mem_rdata  in  8  read byte
- inst_valid  out  1  buffer head valid
- inst_data  out  32  instruction word at head
- inst_pc  out  ADDR_W  PC of head word
- inst_ready  in  1  core accepts head this cycle
- busy  out  1  word assembly in progress

## Operation
- State: pc, fetch_addr, byte counter bcnt[1:0], 24-bit assembly register, buffer (data+pc) with count, FSM {IDLE, FETCH}.
- IDLE: mem_req=0. Go to FETCH when enable==1 and count<DEPTH (room reserved for the word about to start); fetch_addr<=pc, bcnt<=0.
- FETCH: mem_req=1, mem_addr=fetch_addr, held stable until mem_ready. On handshake: byte stored at lane bcnt (byte at pc → inst[7:0], pc+3 → inst[31:24]), fetch_addr+1, bcnt+1.
- On handshake with bcnt==3: push {word, pc} into buffer, pc<=pc+4. Stay in FETCH (fetch_addr=pc+4, bcnt=0) if enable==1 and post-update count<DEPTH; else go to IDLE.
- enable deasserted mid-word: current word completes; no new word starts.
- Buffer pop when inst_valid&&inst_ready; simultaneous push and pop allowed (count unchanged). Push never blocked (space reserved at word start).
- Redirect (highest priority, any state): buffer count<=0, partial word discarded, any handshake that cycle discarded, pc<={redirect_pc[ADDR_W-1:2],2'b00}, FSM<=IDLE. A pop in the same cycle is ignored.
- PC and fetch_addr wrap modulo 2^ADDR_W (0xFFFFFFFC+4 → 0).
- busy = (FSM==FETCH).

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, busy=0, pc=RESET_PC, count=0, FSM=IDLE.
- Reset mid-word: partial word and buffer dropped, and no output glitch after the reset edge.
- mem_req, mem_addr, and busy are registered. inst_* are driven from the buffer head register, with no combinational path from mem_* inputs.
- enable sampled high at edge E0 with mem_ready tied 1: mem_req high in cycles 1–4, inst_valid high from cycle 5.
- Sustained throughput with mem_ready=1 and the core always ready: one word per 4 cycles, with mem_req continuously high (no bubble between words).
- Redirect at edge R: mem_req=0 and inst_valid=0 in cycle R+1, and the first request to the new PC is in cycle R+2 (if enable==1).
- mem_ready low stalls the current byte indefinitely. mem_addr does not change while mem_req=1 and mem_ready=0.

## Test plan
- Basic fetch: mem[0..7]=11 20 52 11 21 04 11 00, RESET_PC=0, ready=1. Expected: inst 0x11522011 @pc 0, then 0x00110421 @pc 4, one word every 4 cycles.
- Backpressure: inst_ready=0, DEPTH=2. Expected: exactly 2 words buffered, mem_req drops to 0 after the 8th byte. After one pop, fetch resumes at pc 8.
- Memory stall: mem_ready toggles 1,0,0,1,… Expected: mem_addr is stable during stalls and the word is assembled correctly.
- Redirect mid-word: redirect_pc=0x13 after 2 bytes. Expected: buffer flushed, next request addr 0x10, and the next inst_pc is 0x10.
- Wrap: RESET_PC=0xFFFFFFFC. Expected: word @0xFFFFFFFC, then the next request addr is 0x0.
- Reset mid-word and enable drop: rst=0 after byte 1, all outputs return to reset values. enable=0 after byte 2, the word completes and no further mem_req follows.
